freq_comp_window: RTL

Parametrised period-measurement frequency comparator for the automatic frequency calibrator loop. The block measures N_CYC full periods of the reference clock and of the divided VCO clock in pre_clk cycles, compares the two counts, and produces the slow/fast/freeze/error flag code for the calibration FSM. Compared with the first-generation comparator, it adds:
- fully synchronous sampling of both clocks,
- configurable window, width and tolerance,
- a start/busy/done handshake,
- a signed difference output,
- a watchdog error path.

---
 rtl/freq_comp_window.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/freq_comp_window.sv
// freq_comp_window: period-measurement frequency comparator for the AFC loop.
// Measures N_CYC full periods of ref_clk and div_clk (both sampled as data in
// the pre_clk domain), compares the counts and reports slow/fast/freeze/error.
//
// Optional feature macro: FREQ_COMP_CONTINUOUS_EN (repeat windows after one start).
//
// Ports:
//   pre_clk        sampling clock, only clock of the block
//   rst            asynchronous active-high reset
//   ref_clk        reference clock (sampled as data)
//   div_clk        divided VCO clock (sampled as data)
//   start          measurement request, accepted only in IDLE
//   busy           high from start acceptance until done
//   done           one-cycle result strobe
//   flags          100 ref>div, 010 div>ref, 001 freeze, 111 error
//   ref_count_out  last ref window count
//   div_count_out  last div window count
//   diff_out       signed ref_count - div_count
module freq_comp_window #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned N_CYC       = 4,
  parameter int unsigned TOL         = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             pre_clk,
  input  logic             rst,
  input  logic             ref_clk,
  input  logic             div_clk,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] ref_count_out,
  output logic [CNT_W-1:0] div_count_out,
  output logic [CNT_W:0]   diff_out
);

  localparam int unsigned EDGE_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(N_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  // Trip two counts early so the COMPARE cycle is the (2^CNT_W-1)-th busy cycle.
  localparam logic [CNT_W-1:0]  WD_TRIP   = CNT_MAX - CNT_W'(2);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);
`ifdef FREQ_COMP_CONTINUOUS_EN
  localparam logic CONTINUOUS = 1'b1;
`else
  localparam logic CONTINUOUS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, COMPARE} state_t;

  state_t state, state_n;

  // Channel index 0 = ref, 1 = div.
  logic [SYNC_STAGES-1:0] ref_sync, div_sync;
  logic [1:0]             sync_prev;
  logic [1:0]             pulse_c;
  logic [1:0]             armed, stopped, stop_c;
  logic [CNT_W-1:0]       cnt [2];
  logic [EDGE_W-1:0]      edges [2];
  logic [CNT_W-1:0]       wd;
  logic                   err_q;
  logic                   clr_c, meas_c, both_done_c, err_c;
  logic signed [CNT_W:0]  diff_c;

  // Synchronisers and rising-edge detectors.
  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) begin
      ref_sync  <= '0;
      div_sync  <= '0;
      sync_prev <= '0;
    end else begin
      ref_sync  <= {ref_sync[SYNC_STAGES-2:0], ref_clk};
      div_sync  <= {div_sync[SYNC_STAGES-2:0], div_clk};
      sync_prev <= {div_sync[SYNC_STAGES-1], ref_sync[SYNC_STAGES-1]};
    end
  end

  assign pulse_c = {div_sync[SYNC_STAGES-1], ref_sync[SYNC_STAGES-1]} & ~sync_prev;

  // A channel stops on its N_CYC-th edge after arming.
  always_comb begin
    stop_c = '0;
    for (int i = 0; i < 2; i++) begin
      stop_c[i] = armed[i] & ~stopped[i] & pulse_c[i] & (edges[i] == LAST_EDGE);
    end
  end

  // Include the stopping edge itself so COMPARE follows the final pulse directly.
  assign both_done_c = &(stopped | stop_c);
  assign err_c       = (wd == WD_TRIP) || (cnt[0] == CNT_MAX) || (cnt[1] == CNT_MAX);
  assign diff_c      = $signed({1'b0, cnt[0]}) - $signed({1'b0, cnt[1]});

  // State register.
  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and control decode.
  always_comb begin
    state_n = state;
    clr_c   = 1'b0;
    meas_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ARM;
          clr_c   = 1'b1;
        end
      end
      ARM: begin
        meas_c = 1'b1;
        if (err_c || both_done_c) state_n = COMPARE;
        else if (&armed)          state_n = MEASURE;
      end
      MEASURE: begin
        meas_c = 1'b1;
        if (err_c || both_done_c) state_n = COMPARE;
      end
      COMPARE: begin
        state_n = CONTINUOUS ? ARM : IDLE;
        clr_c   = CONTINUOUS;
      end
      default: state_n = IDLE;
    endcase
  end

  // Per-channel arm/count/stop, watchdog and error capture.
  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) begin
      armed   <= '0;
      stopped <= '0;
      wd      <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cnt[i]   <= '0;
        edges[i] <= '0;
      end
    end else if (clr_c) begin
      armed   <= '0;
      stopped <= '0;
      wd      <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cnt[i]   <= '0;
        edges[i] <= '0;
      end
    end else begin
      if (state != IDLE && wd != CNT_MAX) wd <= wd + CNT_W'(1);
      if (meas_c) begin
        err_q <= err_c;
        for (int i = 0; i < 2; i++) begin
          if (!armed[i]) begin
            armed[i] <= pulse_c[i];
          end else if (!stopped[i]) begin
            if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
            if (pulse_c[i]) begin
              if (edges[i] == LAST_EDGE) stopped[i] <= 1'b1;
              else                       edges[i]   <= edges[i] + EDGE_W'(1);
            end
          end
        end
      end
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge pre_clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      flags         <= 3'b000;
      ref_count_out <= '0;
      div_count_out <= '0;
      diff_out      <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) busy <= 1'b1;
      if (state == COMPARE) begin
        done          <= 1'b1;
        busy          <= CONTINUOUS;
        ref_count_out <= cnt[0];
        div_count_out <= cnt[1];
        if (err_q) begin
          flags    <= 3'b111;
          diff_out <= '0;
        end else begin
          diff_out <= diff_c;
          if (diff_c >= TOL_S)       flags <= 3'b100;
          else if (diff_c <= -TOL_S) flags <= 3'b010;
          else                       flags <= 3'b001;
        end
      end
    end
  end

endmodule
